// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: data-cache handshake for loads and stores,
// lane alignment, load extension and a registered one-cycle result toward WB.
module mem_stage #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_alu_out,
  input  logic [31:0]            in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic                   in_is_load,
  input  logic                   in_is_store,
  input  logic                   in_regwrite,
  input  logic [4:0]             in_rd,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [31:0]            dmem_address,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_byte_enable,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic                   wb_valid,
  output logic [31:0]            wb_data,
  output logic [4:0]             wb_rd,
  output logic                   wb_regwrite,
  output logic                   wb_misalign,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic        is_load_q;

  logic [1:0]  off_c;
  logic        is_mem_c;
  logic        misalign_c;
  logic        illegal_c;
  logic [3:0]  be_c;
  logic [31:0] shifted_c;
  logic [31:0] load_c;

  assign in_ready = (state == IDLE);

  // Decode of the incoming instruction: legality and lane mask.
  always_comb begin
    off_c      = in_alu_out[1:0];
    is_mem_c   = in_is_load | in_is_store;
    misalign_c = ((in_funct3[1:0] == 2'b01) && off_c[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (off_c != 2'b00));
    if (in_is_load)
      illegal_c = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
    else
      illegal_c = (in_funct3 > 3'b010);
    case (in_funct3[1:0])
      2'b00:   be_c = 4'b0001 << off_c;
      2'b01:   be_c = 4'b0011 << off_c;
      default: be_c = 4'b1111;
    endcase
  end

  // Load extraction from the returned cache word.
  always_comb begin
    shifted_c = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_c = {24'h0, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_c = {16'h0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      addr_q           <= '0;
      funct3_q         <= '0;
      rd_q             <= '0;
      regwrite_q       <= 1'b0;
      is_load_q        <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      wb_valid         <= 1'b0;
      wb_data          <= '0;
      wb_rd            <= '0;
      wb_regwrite      <= 1'b0;
      wb_misalign      <= 1'b0;
      stall_cycles     <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem_c || misalign_c || illegal_c) begin
              // Result goes straight to WB; faulting accesses never reach the cache.
              wb_valid    <= 1'b1;
              wb_data     <= in_alu_out;
              wb_rd       <= in_rd;
              wb_regwrite <= is_mem_c ? 1'b0 : in_regwrite;
              wb_misalign <= is_mem_c;
            end else begin
              state            <= ACCESS;
              addr_q           <= in_alu_out;
              funct3_q         <= in_funct3;
              rd_q             <= in_rd;
              regwrite_q       <= in_regwrite;
              is_load_q        <= in_is_load;
              dmem_read        <= in_is_load;
              dmem_write       <= ~in_is_load;
              dmem_address     <= {in_alu_out[31:2], 2'b00};
              dmem_wdata       <= in_is_load ? 32'h0 : (in_rs2 << {off_c, 3'b000});
              dmem_byte_enable <= be_c;
            end
          end
        end
        ACCESS: begin
          if (stall_cycles != {STALL_CNT_W{1'b1}})
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
          if (dmem_resp) begin
            state       <= IDLE;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= is_load_q ? load_c : addr_q;
            wb_rd       <= rd_q;
            wb_regwrite <= is_load_q & regwrite_q;
            wb_misalign <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a spec-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [31:0] in_rs2;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_misalign;
  logic [31:0] stall_cycles;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = 0;

  always #5 clk = ~clk;

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_regwrite(in_regwrite),
    .in_rd(in_rd), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_misalign(wb_misalign), .stall_cycles(stall_cycles)
  );

  // Reference: is this load/store legal and naturally aligned?
  function automatic bit ref_legal(input bit is_load, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    bit ok;
    if (is_load) ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else         ok = (f3 <= 2);
    size = 1 << (f3 % 4);
    return ok && ((addr % size) == 0);
  endfunction

  // Reference: value a load delivers, from byte arithmetic on the returned word.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] f3);
    logic [31:0] w;
    logic [31:0] v;
    w = rdata / (32'd1 << (8 * (addr % 4)));
    case (f3)
      3'd0:    begin v = w % 256;   if (v >= 128)   v = v - 256;   end
      3'd4:    v = w % 256;
      3'd1:    begin v = w % 65536; if (v >= 32768) v = v - 65536; end
      3'd5:    v = w % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << (f3 % 4);
    return 4'(((1 << size) - 1) << (addr % 4));
  endfunction

  // Present one instruction for a single cycle; returns at posedge+1 after the accept edge.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input bit rw);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_out = addr; in_rs2 = rs2; in_rd = rd; in_regwrite = rw;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    dmem_rdata = rdata; dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write,
         dmem_address, dmem_wdata, dmem_byte_enable, stall_cycles, in_ready} !== {108'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset: wb_valid=%b wb_data=%h dmem_rd=%b dmem_wr=%b stall=%0d in_ready=%b, required all zero with in_ready=1",
               wb_valid, wb_data, dmem_read, dmem_write, stall_cycles, in_ready);
    end
  endtask

  task automatic test_alu;
    issue(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1);
    checks++;
    if ({wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write} !==
        {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alu: got v=%b d=%h rd=%0d rw=%b mis=%b r=%b w=%b, required 1 00001234 5 1 0 0 0",
               wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_pulse: wb_valid=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_store_sb;
    issue(0, 1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dmem_write, dmem_read, dmem_address, dmem_byte_enable, dmem_wdata, in_ready, wb_valid} !==
          {1'b1, 1'b0, 32'h1000, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sb_hold[%0d]: w=%b r=%b a=%h be=%b wd=%h rdy=%b wbv=%b, required 1 0 00001000 1000 ab000000 0 0",
                 i, dmem_write, dmem_read, dmem_address, dmem_byte_enable, dmem_wdata, in_ready, wb_valid);
      end
      // An instruction offered during the access must not be consumed.
      issue(0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd9, 1);
    end
    respond(32'h0);
    exp_stall = exp_stall + 4;
    checks++;
    if ({wb_valid, wb_regwrite, wb_misalign, wb_data, dmem_write, in_ready, stall_cycles} !==
        {1'b1, 1'b0, 1'b0, 32'h1003, 1'b0, 1'b1, exp_stall}) begin
      errors++;
      $display("FAIL sb_done: v=%b rw=%b mis=%b d=%h w=%b rdy=%b stall=%0d, required 1 0 0 00001003 0 1 %0d",
               wb_valid, wb_regwrite, wb_misalign, wb_data, dmem_write, in_ready, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_loads;
    logic [31:0] addrs [4] = '{32'h2002, 32'h2002, 32'h3002, 32'h3000};
    logic [31:0] rdat  [4] = '{32'h00F0_0000, 32'h00F0_0000, 32'h8001_0000, 32'h8001_0000};
    logic [2:0]  f3s   [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
    logic [31:0] expv  [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h8001_0000};
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, f3s[i], addrs[i], 32'h0, 5'(10 + i), 1);
      checks++;
      if ({dmem_read, dmem_write, dmem_address} !== {1'b1, 1'b0, addrs[i] & 32'hFFFF_FFFC}) begin
        errors++;
        $display("FAIL load_req[%0d]: r=%b w=%b a=%h, required 1 0 %h", i, dmem_read, dmem_write,
                 dmem_address, addrs[i] & 32'hFFFF_FFFC);
      end
      respond(rdat[i]);
      exp_stall = exp_stall + 1;
      checks++;
      if ({wb_valid, wb_data, wb_rd, wb_regwrite, dmem_read} !== {1'b1, expv[i], 5'(10 + i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL load_data[%0d]: v=%b d=%h rd=%0d rw=%b r=%b, required 1 %h %0d 1 0",
                 i, wb_valid, wb_data, wb_rd, wb_regwrite, dmem_read, expv[i], 10 + i);
      end
    end
  endtask

  task automatic test_misalign;
    issue(1, 0, 3'd2, 32'h0000_4001, 32'h0, 5'd7, 1);
    checks++;
    if ({wb_valid, wb_misalign, wb_regwrite, wb_data, dmem_read, in_ready} !==
        {1'b1, 1'b1, 1'b0, 32'h4001, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL misalign: v=%b mis=%b rw=%b d=%h r=%b rdy=%b, required 1 1 0 00004001 0 1",
               wb_valid, wb_misalign, wb_regwrite, wb_data, dmem_read, in_ready);
    end
  endtask

  task automatic test_reset_mid_access;
    issue(1, 0, 3'd2, 32'h0000_5000, 32'h0, 5'd3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({dmem_read, wb_valid, in_ready, stall_cycles} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_abort: r=%b wbv=%b rdy=%b stall=%0d, required 0 0 1 0",
               dmem_read, wb_valid, in_ready, stall_cycles);
    end
    exp_stall = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    respond(32'hFFFF_FFFF);
    checks++;
    if ({wb_valid, dmem_read, in_ready, stall_cycles} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL spurious_resp: wbv=%b r=%b rdy=%b stall=%0d, required 0 0 1 0",
               wb_valid, dmem_read, in_ready, stall_cycles);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int          kind;
      int          waits;
      bit          ld, st, rw, legal;
      logic [2:0]  f3;
      logic [31:0] addr, rs2, rdata, expd;
      logic [4:0]  rd;
      kind  = int'($urandom_range(0, 2));
      ld    = (kind == 1);
      st    = (kind == 2);
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      rs2   = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom);
      rw    = 1'($urandom);
      waits = int'($urandom_range(0, 3));
      legal = (kind != 0) && ref_legal(ld, f3, addr);
      issue(ld, st, f3, addr, rs2, rd, rw);
      if (!legal) begin
        checks++;
        if ({wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write} !==
            {1'b1, addr, rd, (kind == 0) ? rw : 1'b0, kind != 0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rand_direct[%0d]: kind=%0d f3=%0d v=%b d=%h rd=%0d rw=%b mis=%b r=%b w=%b",
                   n, kind, f3, wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write);
        end
      end else begin
        for (int w = 0; w <= waits; w++) begin
          checks++;
          if ({dmem_read, dmem_write, dmem_address, in_ready, wb_valid} !== {ld, st, addr & 32'hFFFF_FFFC, 1'b0, 1'b0} ||
              (st && {dmem_byte_enable, dmem_wdata} !== {ref_be(f3, addr), rs2 << (8 * (addr % 4))})) begin
            errors++;
            $display("FAIL rand_req[%0d.%0d]: f3=%0d addr=%h r=%b w=%b a=%h be=%b wd=%h rdy=%b",
                     n, w, f3, addr, dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, in_ready);
          end
          if (w < waits) begin
            @(posedge clk); #1;
          end
        end
        respond(rdata);
        exp_stall = exp_stall + 32'(waits + 1);
        expd = ld ? ref_load(rdata, addr, f3) : addr;
        checks++;
        if ({wb_valid, wb_data, wb_rd, wb_regwrite, wb_misalign, dmem_read, dmem_write, in_ready, stall_cycles} !==
            {1'b1, expd, rd, ld & rw, 1'b0, 1'b0, 1'b0, 1'b1, exp_stall}) begin
          errors++;
          $display("FAIL rand_done[%0d]: f3=%0d addr=%h d=%h exp_d=%h rd=%0d rw=%b stall=%0d exp_stall=%0d",
                   n, f3, addr, wb_data, expd, wb_rd, wb_regwrite, stall_cycles, exp_stall);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_alu_out = '0; in_rs2 = '0; in_funct3 = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_regwrite = 1'b0; in_rd = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    test_alu;
    test_store_sb;
    test_loads;
    test_misalign;
    test_random;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the RV32I pipeline, fed by the EX/MEM register. Takes the EX result (ALU output as address or pass-through value), store data (rs2), funct3, rd and control bits.
- Runs the data-cache handshake for loads and stores: byte-lane alignment, store shifting, load extraction with sign/zero extension.
- Presents a registered, one-cycle-valid result to WB.
- Stalls upstream while a cache access is outstanding.

Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- in_valid  input  1  EX/MEM holds a valid instruction.
- in_ready  output  1  stage accepts an instruction this cycle.
- in_alu_out  input  32  EX ALU result; the address for loads and stores, else the writeback value.
- in_rs2  input  32  store data.
- in_funct3  input  3  load/store width and signedness.
- in_is_load  input  1  instruction is a load.
- in_is_store  input  1  instruction is a store.
- in_regwrite  input  1  instruction writes rd.
- in_rd  input  5  destination register.
- dmem_read  output  1  cache read request.
- dmem_write  output  1  cache write request.
- dmem_address  output  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  output  32  lane-shifted store data.
- dmem_byte_enable  output  4  active byte lanes.
- dmem_rdata  input  32  cache read word.
- dmem_resp  input  1  one-cycle cache completion.
- wb_valid  output  1  one-cycle pulse; WB fields valid.
- wb_data  output  32  load result or pass-through ALU value.
- wb_rd  output  5  destination register.
- wb_regwrite  output  1  write enable to the register file.
- wb_misalign  output  1  access was misaligned or had an illegal funct3; no cache access was made.
- stall_cycles  output  STALL_CNT_W  count of cycles spent in ACCESS (saturating).

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0: wb_*, dmem_*, stall_cycles.
  - Held operand registers are cleared.
- FSM states: IDLE, ACCESS.
- IDLE:
  - in_ready=1.
  - An instruction is accepted when in_valid=1.
- Non-memory accept (is_load=is_store=0):
  - Next cycle: wb_valid=1, wb_data=in_alu_out, wb_rd=in_rd, wb_regwrite=in_regwrite, wb_misalign=0.
  - Latency 1. Stays in IDLE.
- Memory accept, alignment check:
  - Misaligned cases: funct3[1:0]=01 with addr[0]=1; funct3[1:0]=10 with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Either condition: no cache request. Next cycle wb_valid=1, wb_misalign=1, wb_regwrite=0, wb_data=in_alu_out. Stays in IDLE.
- Memory accept, legal access:
  - Operands are latched and the FSM moves to ACCESS.
  - dmem_read or dmem_write is driven from registers starting the next cycle.
- ACCESS:
  - in_ready=0.
  - dmem_read/dmem_write, dmem_address, dmem_wdata and dmem_byte_enable are held stable until the cycle dmem_resp=1.
  - Request drops the cycle after dmem_resp.
  - stall_cycles increments every ACCESS cycle and saturates at all-ones.
- Store lanes, off = addr[1:0]:
  - sb: byte_enable = 0001<<off.
  - sh: byte_enable = 0011<<off.
  - sw: byte_enable = 1111.
  - dmem_wdata = in_rs2 << (8*off).
- Load extraction, off = addr[1:0]:
  - Shift dmem_rdata right by 8*off.
  - lb/lh: sign-extend from bit 7 / bit 15.
  - lbu/lhu: zero-extend.
  - lw: no change.
- Completion:
  - On the dmem_resp cycle the WB registers load and the FSM returns to IDLE.
  - wb_valid=1 the following cycle.
  - Load: wb_data=extracted value, wb_regwrite=latched regwrite.
  - Store: wb_regwrite=0, wb_data=latched addr.
- Accept timing:
  - in_ready goes high the cycle after resp. Back-to-back issue is therefore min 1 idle cycle after each memory op.
  - A new accept in IDLE does not depend on dmem_resp.
- Boundary cases:
  - dmem_resp outside ACCESS is ignored.
  - in_valid during ACCESS is not consumed.
  - Reset mid-ACCESS aborts: request deasserts immediately and no wb_valid pulse is produced.

Test Plan:
- ADD result: in_alu_out=0x0000_1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, no dmem activity.
- sb: addr=0x1003, rs2=0x0000_00AB -> dmem_write=1, address=0x1000, byte_enable=1000, wdata=0xAB00_0000. Held through 3 wait cycles; resp -> wb_valid, wb_regwrite=0, stall_cycles=4.
- lb: addr=0x2002, rdata=0x00F0_0000 -> wb_data=0xFFFF_FFF0. lbu at the same address -> 0x0000_00F0.
- lh: addr=0x3002, rdata=0x8001_0000 -> wb_data=0xFFFF_8001. lw: addr=0x3000 -> 0x8001_0000.
- Misaligned lw: addr=0x4001 -> no dmem_read, wb_misalign=1, wb_regwrite=0, one cycle.
- Reset asserted while in ACCESS with dmem_resp pending -> dmem_read=0 asynchronously, state IDLE, no wb_valid. A spurious dmem_resp afterwards is ignored.
